// File: rtl/sar_pkg.sv
// Shared definitions for the successive-approximation search controller.
package sar_pkg;

  localparam int SAR_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } sar_state_e;

endpackage

// File: rtl/sar_search_4bits.sv
// Binary-search controller: drives trial into an external comparator and
// recovers the unknown operand MSB first, one comparison per clock.
module sar_search_4bits
  import sar_pkg::*;
#(
  parameter int WIDTH = SAR_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       cmp_eq,
  input  logic                       cmp_gt,
  input  logic                       cmp_lt,
  output logic [WIDTH-1:0]           trial,
  output logic                       busy,
  output logic                       done,
  output logic [WIDTH-1:0]           result,
  output logic                       err,
  output logic [$clog2(WIDTH+1)-1:0] steps
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int SW = $clog2(WIDTH + 1);

  sar_state_e       state_q, state_d;
  logic [WIDTH-1:0] trial_q, trial_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [SW-1:0]    steps_q, steps_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] bit_cur;
  logic [WIDTH-1:0] bit_next;
  logic             flags_onehot;

  always_comb begin
    bit_cur      = WIDTH'(1) << idx_q;
    bit_next     = bit_cur >> 1;
    flags_onehot = ({cmp_eq, cmp_gt, cmp_lt} == 3'b100) ||
                   ({cmp_eq, cmp_gt, cmp_lt} == 3'b010) ||
                   ({cmp_eq, cmp_gt, cmp_lt} == 3'b001);
  end

  always_comb begin
    state_d  = state_q;
    trial_d  = trial_q;
    result_d = result_q;
    idx_d    = idx_q;
    steps_d  = steps_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        trial_d = '0;
        if (start) begin
          trial_d = WIDTH'(1) << (WIDTH - 1);
          idx_d   = IW'(WIDTH - 1);
          err_d   = 1'b0;
          steps_d = '0;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        steps_d = steps_q + SW'(1);
        if (!flags_onehot) begin
          err_d    = 1'b1;
          result_d = '0;
          state_d  = DONE;
        end else if (cmp_eq) begin
          result_d = trial_q;
          state_d  = DONE;
        end else if (cmp_gt) begin
          if (idx_q == '0) begin
            result_d = trial_q;
            state_d  = DONE;
          end else begin
            trial_d = trial_q | bit_next;
            idx_d   = idx_q - IW'(1);
          end
        end else begin
          // Operand is below trial: drop the current bit, try the next one down.
          if (idx_q == '0) begin
            result_d = trial_q & ~bit_cur;
            state_d  = DONE;
          end else begin
            trial_d = (trial_q & ~bit_cur) | bit_next;
            idx_d   = idx_q - IW'(1);
          end
        end
      end
      DONE: begin
        trial_d = '0;
        state_d = IDLE;
      end
      default: begin
        trial_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      trial_q  <= '0;
      result_q <= '0;
      idx_q    <= '0;
      steps_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      trial_q  <= trial_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      steps_q  <= steps_d;
      err_q    <= err_d;
    end
  end

  assign trial  = trial_q;
  assign busy   = (state_q == COMPARE);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign err    = err_q;
  assign steps  = steps_q;

endmodule

// File: tb/tb_sar_search_4bits.sv
// Self-checking bench: behavioural comparator plus a binary-search reference.
module tb_sar_search_4bits;

  localparam int W  = 4;
  localparam int SW = $clog2(W + 1);

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          cmp_eq, cmp_gt, cmp_lt;
  logic [W-1:0]  trial;
  logic          busy, done, err;
  logic [W-1:0]  result;
  logic [SW-1:0] steps;

  logic [W-1:0]  a_val;
  logic          force_bad;

  int errors = 0;
  int checks = 0;

  sar_search_4bits #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .cmp_eq (cmp_eq),
    .cmp_gt (cmp_gt),
    .cmp_lt (cmp_lt),
    .trial  (trial),
    .busy   (busy),
    .done   (done),
    .result (result),
    .err    (err),
    .steps  (steps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparator: A on one side, trial on the other; optionally corrupted flags.
  always_comb begin
    if (force_bad) begin
      cmp_eq = 1'b0;
      cmp_gt = 1'b1;
      cmp_lt = 1'b1;
    end else begin
      cmp_eq = (a_val == trial);
      cmp_gt = (a_val >  trial);
      cmp_lt = (a_val <  trial);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: classic binary search over [0, 2^W), MSB first, stop on equality.
  // force_at > 0 corrupts the flags on that compare cycle.
  task automatic run_search(input logic [W-1:0] a, input int force_at, input bit hold_start);
    int seq[$];
    int acc;
    int exp_steps, exp_result, exp_err;
    int n, k;
    bit done_seen;
    logic [W-1:0] held_result;
    logic         held_err;
    logic [SW-1:0] held_steps;

    acc = 0;
    for (int b = W - 1; b >= 0; b--) begin
      int t;
      t = acc + (1 << b);
      seq.push_back(t);
      if (t == int'(a)) break;
      if (int'(a) > t) acc = t;
    end
    exp_steps  = seq.size();
    exp_result = int'(a);
    exp_err    = 0;
    if (force_at > 0 && force_at <= exp_steps) begin
      exp_steps  = force_at;
      exp_result = 0;
      exp_err    = 1;
    end

    a_val = a;
    @(negedge clk);
    start = 1'b1;
    n = 0;
    k = 0;
    done_seen = 1'b0;
    while (!done_seen && n < 12) begin
      @(posedge clk);
      #1;
      n++;
      if (!hold_start) start = 1'b0;
      force_bad = (n == force_at);
      if (busy) begin
        if (k < exp_steps) check("trial_seq", trial, seq[k]);
        k++;
      end
      if (done) begin
        done_seen = 1'b1;
        start     = 1'b0;
        force_bad = 1'b0;
        check("done_cycle", n, exp_steps + 1);
        check("result", result, exp_result);
        check("err", err, exp_err);
        check("steps", steps, exp_steps);
        check("busy_in_done", busy, 0);
      end
    end
    start     = 1'b0;
    force_bad = 1'b0;
    check("done_timeout", done_seen, 1);
    check("compare_cycles", k, exp_steps);

    held_result = result;
    held_err    = err;
    held_steps  = steps;
    @(posedge clk);
    #1;
    check("done_one_cycle", done, 0);
    check("idle_busy", busy, 0);
    check("idle_trial", trial, 0);
    check("held_result", result, exp_result);
    check("held_err", err, exp_err);
    check("held_steps", steps, exp_steps);
    check("held_result_stable", result, held_result);
    check("held_err_stable", err, held_err);
    check("held_steps_stable", steps, held_steps);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    a_val     = '0;
    force_bad = 1'b0;
    #12;
    check("rst_trial", trial, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_err", err, 0);
    check("rst_steps", steps, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_search(4'b0101, 0, 1'b0);
    run_search(4'b1000, 0, 1'b0);
    run_search(4'b0000, 0, 1'b0);
    run_search(4'b1111, 0, 1'b0);
    run_search(4'b0110, 2, 1'b0);
    run_search(4'b0110, 0, 1'b0);
    run_search(4'b1001, 0, 1'b1);
    run_search(4'b0001, 0, 1'b1);

    // Asynchronous reset during the third compare.
    a_val = 4'b1010;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("arst_trial", trial, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_result", result, 0);
    check("arst_err", err, 0);
    check("arst_steps", steps, 0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("rst_no_done", done, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_search(4'b0011, 0, 1'b0);

    for (int r = 0; r < 24; r++) begin
      logic [W-1:0] a;
      int fa;
      a  = W'($urandom_range(0, (1 << W) - 1));
      fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W)) : 0;
      run_search(a, fa, bit'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
